// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Detects ecall/ebreak/mret and
//               enabled interrupts, writes mepc/mstatus/mcause one per cycle,
//               then pulses a PC redirect. Optional macro
//               TRAP_CTRL_VECTORED_EN enables vectored interrupt targets.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_ecall_i,
    input  logic        inst_ebreak_i,
    input  logic        inst_mret_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MSTATUS = 3'd2,
        W_MCAUSE  = 3'd3,
        MRET      = 3'd4,
        ASSERT    = 3'd5
    } state_t;

    localparam logic [31:0] C_CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] C_CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] C_CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] C_CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        is_mret_q, is_mret_d;

    logic        w_sync;
    logic        w_irq_ext;
    logic        w_irq_tmr;
    logic        w_mret;
    logic        w_take_irq;
    logic [31:0] w_trap_vec;
    logic        w_unused;

    assign w_sync     = inst_valid_i & (inst_ecall_i | inst_ebreak_i);
    assign w_irq_ext  = inst_valid_i & mstatus_i[3] & ext_irq_i & mie_i[11];
    assign w_irq_tmr  = inst_valid_i & mstatus_i[3] & timer_irq_i & mie_i[7];
    assign w_mret     = inst_valid_i & inst_mret_i & ~w_sync;
    assign w_take_irq = (w_irq_ext | w_irq_tmr) & ~w_sync & ~w_mret;

`ifdef TRAP_CTRL_VECTORED_EN
    // Only interrupts vector; synchronous traps always land on the base.
    always_comb begin
        w_trap_vec = {mtvec_i[31:2], 2'b00};
        if ((mtvec_i[1:0] == 2'b01) && cause_q[31]) begin
            w_trap_vec = {mtvec_i[31:2], 2'b00} + {26'd0, cause_q[3:0], 2'b00};
        end
    end
`else
    assign w_trap_vec = {mtvec_i[31:2], 2'b00};
`endif

    assign w_unused = &{1'b0, mtvec_i[1:0], mie_i[31:12], mie_i[10:8], mie_i[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            is_mret_q <= is_mret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        is_mret_d    = is_mret_q;
        csr_we_o     = 1'b0;
        csr_waddr_o  = 32'd0;
        csr_wdata_o  = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        // Detect terms are gated by rst_n so every output is low during reset.
        stall_o      = (state_q != IDLE) | (rst_n & (w_sync | w_mret | w_take_irq));

        case (state_q)
            IDLE: begin
                if (w_sync) begin
                    cause_d   = inst_ecall_i ? C_CAUSE_ECALL : C_CAUSE_EBREAK;
                    epc_d     = inst_addr_i;
                    is_mret_d = 1'b0;
                    state_d   = W_MEPC;
                end else if (w_mret) begin
                    is_mret_d = 1'b1;
                    state_d   = MRET;
                end else if (w_take_irq) begin
                    cause_d   = w_irq_ext ? C_CAUSE_EXT : C_CAUSE_TIMER;
                    epc_d     = jump_flag_i ? jump_addr_i : inst_addr_i;
                    is_mret_d = 1'b0;
                    state_d   = W_MEPC;
                end
            end
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MEPC;
                csr_wdata_o = epc_q;
                state_d     = W_MSTATUS;
            end
            W_MSTATUS: begin
                // MPIE <- MIE, MIE <- 0
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
                state_d     = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = ASSERT;
            end
            MRET: begin
                // MIE <- MPIE, MPIE <- 1
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
                state_d     = ASSERT;
            end
            ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = is_mret_q ? mepc_i : w_trap_vec;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
